// File: rtl/tt_um_morse_code.sv
// Single-key Morse decoder: times key presses and gaps in DOT_CYCLES units, emits ASCII per character.
// Optional word-space emission is enabled by defining MORSE_WORD_SPACE_EN.
module tt_um_morse_code #(
  parameter int DOT_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] HALF = 16'(DOT_CYCLES / 2);
  localparam logic [15:0] DASH = 16'(2 * DOT_CYCLES);
  localparam logic [15:0] CEND = 16'(3 * DOT_CYCLES);
`ifdef MORSE_WORD_SPACE_EN
  localparam logic [15:0] WEND = 16'(7 * DOT_CYCLES);
`endif

  logic        key_q, key_d;
  logic [15:0] press_q, press_d, gap_q, gap_d;
  logic [4:0]  code_q, code_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  ascii_q, ascii_d;
  logic        err_q, err_d, valid_q, valid_d, space_q, space_d, pend_q, pend_d;
  logic        elem_vld, elem_dash;
  logic [7:0]  dec;

  logic unused_ok;
  assign unused_ok = ^{uio_in, ui_in[7:1]};

  // Code holds the last cnt elements right-aligned, first element in the highest of those bits.
  function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] c);
    case ({n, c})
      {3'd2, 5'b00001}: decode = 8'h41; {3'd4, 5'b01000}: decode = 8'h42;
      {3'd4, 5'b01010}: decode = 8'h43; {3'd3, 5'b00100}: decode = 8'h44;
      {3'd1, 5'b00000}: decode = 8'h45; {3'd4, 5'b00010}: decode = 8'h46;
      {3'd3, 5'b00110}: decode = 8'h47; {3'd4, 5'b00000}: decode = 8'h48;
      {3'd2, 5'b00000}: decode = 8'h49; {3'd4, 5'b00111}: decode = 8'h4A;
      {3'd3, 5'b00101}: decode = 8'h4B; {3'd4, 5'b00100}: decode = 8'h4C;
      {3'd2, 5'b00011}: decode = 8'h4D; {3'd2, 5'b00010}: decode = 8'h4E;
      {3'd3, 5'b00111}: decode = 8'h4F; {3'd4, 5'b00110}: decode = 8'h50;
      {3'd4, 5'b01101}: decode = 8'h51; {3'd3, 5'b00010}: decode = 8'h52;
      {3'd3, 5'b00000}: decode = 8'h53; {3'd1, 5'b00001}: decode = 8'h54;
      {3'd3, 5'b00001}: decode = 8'h55; {3'd4, 5'b00001}: decode = 8'h56;
      {3'd3, 5'b00011}: decode = 8'h57; {3'd4, 5'b01001}: decode = 8'h58;
      {3'd4, 5'b01011}: decode = 8'h59; {3'd4, 5'b01100}: decode = 8'h5A;
      {3'd5, 5'b11111}: decode = 8'h30; {3'd5, 5'b01111}: decode = 8'h31;
      {3'd5, 5'b00111}: decode = 8'h32; {3'd5, 5'b00011}: decode = 8'h33;
      {3'd5, 5'b00001}: decode = 8'h34; {3'd5, 5'b00000}: decode = 8'h35;
      {3'd5, 5'b10000}: decode = 8'h36; {3'd5, 5'b11000}: decode = 8'h37;
      {3'd5, 5'b11100}: decode = 8'h38; {3'd5, 5'b11110}: decode = 8'h39;
      default:          decode = 8'h3F;
    endcase
  endfunction

  assign dec = ovf_q ? 8'h3F : decode(cnt_q, code_q);

  always_comb begin
    key_d     = ui_in[0];
    press_d   = press_q;
    gap_d     = gap_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ascii_d   = ascii_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    space_d   = 1'b0;
    pend_d    = pend_q;
    elem_vld  = 1'b0;
    elem_dash = 1'b0;
    if (key_q) begin
      press_d = (press_q == 16'hFFFF) ? press_q : press_q + 16'd1;
      gap_d   = 16'd0;
      pend_d  = 1'b0;
    end else begin
      // First low cycle after a press: classify and release the press counter.
      if (press_q != 16'd0) begin
        press_d   = 16'd0;
        elem_vld  = (press_q >= HALF);
        elem_dash = (press_q >= DASH);
      end
      if (elem_vld) begin
        if (cnt_q == 3'd5) ovf_d = 1'b1;
        else begin
          code_d = {code_q[3:0], elem_dash};
          cnt_d  = cnt_q + 3'd1;
        end
      end
      if (cnt_d != 3'd0) begin
        gap_d = gap_q + 16'd1;
        if (gap_d == CEND) begin
          ascii_d = dec;
          err_d   = (dec == 8'h3F);
          valid_d = 1'b1;
          code_d  = 5'd0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          pend_d  = 1'b1;
        end
      end
`ifdef MORSE_WORD_SPACE_EN
      else if (pend_q) begin
        gap_d = gap_q + 16'd1;
        if (gap_d == WEND) begin
          ascii_d = 8'h20;
          valid_d = 1'b1;
          space_d = 1'b1;
          pend_d  = 1'b0;
        end
      end
`else
      pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= 1'b0;
      press_q <= 16'd0;
      gap_q   <= 16'd0;
      code_q  <= 5'd0;
      cnt_q   <= 3'd0;
      ovf_q   <= 1'b0;
      ascii_q <= 8'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      space_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (ena) begin
      key_q   <= key_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ascii_q <= ascii_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      space_q <= space_d;
      pend_q  <= pend_d;
    end
  end

  assign uo_out  = ascii_q;
  assign uio_out = {space_q, cnt_q, key_q, key_q, err_q, valid_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_morse_code.sv
// Bench for tt_um_morse_code: directed Morse scenarios plus random characters checked
// against a string-table model of ITU Morse and the dot/dash timing thresholds.
module tb_tt_um_morse_code;
  localparam int D = 10;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_morse_code #(.DOT_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  string MORSE [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                        "---..", "----."};
  string CHARS = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  always @(negedge clk) if (uio_out[0] === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Key high for exactly n cycles; the upper ui_in bits and uio_in carry noise.
  task automatic press(input int n);
    ui_in  = {7'($urandom), 1'b1};
    uio_in = 8'($urandom);
    repeat (n) step();
    ui_in  = {7'($urandom), 1'b0};
  endtask

  function automatic string classify(input int n);
    if (n < D / 2)     return "";
    if (n < 2 * D)     return ".";
    return "-";
  endfunction

  function automatic logic [7:0] ref_char(input string s);
    if (s.len() > 5) return 8'h3F;
    for (int i = 0; i < 36; i++) if (MORSE[i] == s) return CHARS[i];
    return 8'h3F;
  endfunction

  task automatic wait_char(input logic [7:0] exp_c, input logic exp_err);
    int c;
    int p0;
    c  = 0;
    p0 = pulses;
    do begin step(); c++; end while (uio_out[0] !== 1'b1 && c < 3 * D + 6);
    check("char_latency", c, 3 * D + 1);
    check("char_ascii", uo_out, exp_c);
    check("char_err", uio_out[1], exp_err);
    check("char_cnt_clr", uio_out[6:4], 0);
    step();
    check("char_pulse_1cyc", uio_out[0], 0);
    check("char_pulse_count", pulses - p0, 1);
  endtask

  // Plays presses with the given durations and inter-press gaps, then checks the emitted char.
  task automatic send(input int q[$], input int g[$]);
    string s;
    int    mc;
    s  = "";
    mc = 0;
    for (int i = 0; i < q.size(); i++) begin
      press(q[i]);
      s = {s, classify(q[i])};
      if (classify(q[i]) != "" && mc < 5) mc++;
      if (i < q.size() - 1) begin
        idle(g[i]);
        if (g[i] >= 2) check("elem_count", uio_out[6:4], mc);
      end
    end
    wait_char(ref_char(s), ref_char(s) == 8'h3F);
  endtask

  initial begin
    int    q[$];
    int    g[$];
    int    c, p0;
    string pat;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    idle(3);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    idle(200);
    check("idle_uo", uo_out, 8'h00);
    check("idle_uio", uio_out, 8'h00);
    check("idle_oe", uio_oe, 8'hFF);

    press(5);
    check("key_sync", uio_out[3:2], 2'b11);
    idle(5);
    check("key_release", uio_out[3:2], 2'b00);
    idle(3 * D + 5);

    q = '{10, 30};        g = '{10};      send(q, g);   // A
    q = '{3, 10};         g = '{10};      send(q, g);   // glitch then E
    q = '{D/2, 2*D-1, 2*D}; g = '{12, 3*D-1}; send(q, g); // ..- boundaries
    q = '{D/2 - 1, 2*D};  g = '{7};       send(q, g);   // glitch then T
    q = '{10, 10, 10, 10, 10, 10}; g = '{10, 10, 10, 10, 10}; send(q, g); // overflow
    q = '{10, 10, 10, 30, 30}; g = '{10, 10, 10, 10}; send(q, g); // 3

    // Word space after 'A'
    q = '{10, 30}; g = '{10}; send(q, g);
    p0 = pulses;
    c  = 0;
`ifdef MORSE_WORD_SPACE_EN
    do begin step(); c++; end while (uio_out[0] !== 1'b1 && c < 4 * D + 5);
    check("space_latency", c, 4 * D - 1);
    check("space_ascii", uo_out, 8'h20);
    check("space_flag", uio_out[7], 1);
    step();
    check("space_flag_1cyc", uio_out[7], 0);
    idle(10 * D);
    check("space_once", pulses - p0, 1);
`else
    idle(8 * D);
    check("nospace_pulses", pulses - p0, 0);
    check("nospace_ascii", uo_out, 8'h41);
    check("nospace_flag", uio_out[7], 0);
`endif

    // Enable low freezes everything, including the key synchroniser.
    ena = 1'b0;
    press(40);
    check("ena_hold_key", uio_out[3:2], 2'b00);
    check("ena_hold_cnt", uio_out[6:4], 0);
    ena = 1'b1;
    idle(5);

    for (int it = 0; it < 24; it++) begin
      int k;
      k = $urandom_range(39, 0);
      if (k < 36) pat = MORSE[k];
      else begin
        pat = "";
        for (int j = 0; j < $urandom_range(6, 1); j++) pat = {pat, ($urandom_range(1, 0) != 0) ? "-" : "."};
      end
      q.delete();
      g.delete();
      for (int j = 0; j < pat.len(); j++) begin
        if ($urandom_range(3, 0) == 0) begin
          q.push_back($urandom_range(D / 2 - 1, 1));
          g.push_back($urandom_range(3 * D - 1, 2));
        end
        q.push_back(pat.substr(j, j) == "." ? $urandom_range(2 * D - 1, D / 2) : $urandom_range(3 * D, 2 * D));
        if (j < pat.len() - 1) g.push_back($urandom_range(3 * D - 1, 2));
      end
      send(q, g);
      idle($urandom_range(8, 2));
    end

    // Reset mid-character discards it.
    rst_n = 1'b1;
    press(10); idle(10); press(10); idle(5);
    check("pre_rst_cnt", uio_out[6:4], 2);
    p0 = pulses;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10 * D);
    check("rst_mid_pulses", pulses - p0, 0);
    check("rst_mid_uo", uo_out, 8'h00);
    check("rst_mid_uio", uio_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
